issue_ctrl: RTL
===============

# issue_ctrl

Issue and hazard controller between decode and execute. Each cycle it decides whether the instruction held in decode may issue. It stalls on load-use hazards, on RAW/WAW hazards against the in-flight multiplier pipeline, and on conflicts for the single register-file write port shared by the ALU/memory pipe and the multiplier pipe. It drives the decode-stage write enable, the execute bubble and the write-back source select.

## Interface
- MULT_LAT, 5: multiplier pipeline depth M1..M(MULT_LAT); legal 3..8.
- REG_ADDR, 5: register address width.

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- id_valid  in  1  decode holds a valid instruction
- id_src1  in  REG_ADDR  source register 1
- id_src2  in  REG_ADDR  source register 2
- id_use_src2  in  1  src2 is read (0 for immediate/load forms)
- id_dest  in  REG_ADDR  destination register
- id_regwrite  in  1  instruction writes the register file
- id_memread  in  1  instruction is a load
- id_is_mult  in  1  instruction goes to the multiplier pipe
- ext_stall  in  1  downstream freeze (memory miss)
- fd_we  out  1  enable for the PC and decode boundary registers (decode `we`)
- id_issue  out  1  decode instruction issues this cycle
- ex_bubble  out  1  decode boundary loads a NOP (regwrite/memwrite/memread/branch forced 0)
- wb_sel  out  1  registered; 1 = write port driven by the multiplier pipe this cycle
- mult_busy  out  1  any multiplier stage valid
- stall_cause  out  2  registered; 00 none, 01 load-use, 10 mult RAW/WAW, 11 write-port conflict

## Operation
- State:
  - EX shadow: valid, dest, memread of the last ALU-pipe issue.
  - Mult shadow s[1..MULT_LAT]: valid, dest.
  - Write-port reservation vector R[1..MULT_LAT+1]. R[k] = write port taken k cycles from now.
- Write-back latency L from decode: ALU/load = 3; mult = MULT_LAT+1.
- Hazards are evaluated only when id_valid=1. A register match requires a nonzero register; r0 never matches. src2 counts only if id_use_src2.
  - Load-use (01): EX shadow valid & memread & dest matches src1/src2.
  - Mult (10): any s[k] valid & dest matches src1/src2, or id_regwrite & dest == id_dest (WAW).
  - Port (11): id_regwrite & R[L]=1.
  - Priority when several hold: 01 > 10 > 11.
- Combinational outputs:
  - hazard = any of the above.
  - id_issue = id_valid & ~hazard & ~ext_stall.
  - fd_we = ~ext_stall & ~(id_valid & hazard).
  - ex_bubble = ~ext_stall & ~id_issue.
  - mult_busy = OR of s[k].valid.
- Per clock edge with ext_stall=0:
  - Shift the mult shadow: s[k+1] <= s[k]; s[1] <= issue of mult.
  - EX shadow <= issuing non-mult instruction, else invalid.
  - R[k] <= R[k+1], R[MULT_LAT+1] <= 0; on issue with id_regwrite, also set R[L-1].
  - wb_sel <= s[MULT_LAT].valid.
  - stall_cause <= current cause (00 if issued or id_valid=0).
- ext_stall=1:
  - All state and registered outputs hold.
  - fd_we=0, id_issue=0, ex_bubble=0.
  - Timing is frozen uniformly across both pipes, so reservations stay consistent.
- Register file is write-first. A mult result read in its WB cycle needs no stall.
- A mult occupying the port at the slot an ALU op would use always wins; the ALU op waits.

## Timing
- Reset (asynchronous, reset=0):
  - All shadows invalid, R=0, wb_sel=0, stall_cause=00, mult_busy=0.
  - With id_valid=0 or no hazard: fd_we=1.
- Release is synchronous to the next edge; no issue occurs while reset=0.
- Decision latency 0 cycles: hazard outputs are valid in the same cycle the instruction sits in decode.
- Load-use costs exactly 1 bubble.
- A dependent of a mult issued at edge e0 stalls through cycles 1..MULT_LAT and issues in cycle MULT_LAT+1, its WB cycle.
- Reset mid-operation discards all in-flight tracking. The multiplier datapath is reset by the same signal.

## Test plan
- Load r3, then add r4=r3+r1 next cycle -> one cycle fd_we=0, ex_bubble=1, stall_cause=01; add issues the following cycle.
- MULT_LAT=5: mul r5 at cycle 0, add r6=r5+r2 in decode at cycle 1 -> stalls cycles 1..5 (cause 10), issues cycle 6; wb_sel=1 in cycle 6.
- mul r5 at cycle 0, independent adds in cycles 1,2,3 -> cycles 1,2 issue; cycle 3 stalls one cycle (cause 11), issues cycle 4; port never double-booked.
- mul r5 issued, ext_stall=1 for 3 cycles at cycle 2 -> all outputs frozen, fd_we=0, ex_bubble=0; mult WB delayed by 3 cycles to cycle 9.
- load r0, then use r0; mul r7 then add r7=... (WAW) -> r0 case issues with no stall; WAW stalls with cause 10 until the mult leaves s[MULT_LAT].
- Assert reset at cycle 2 of an in-flight mul r5 -> mult_busy=0, wb_sel=0 immediately; after release, a dependent add on r5 issues without a stall.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue and hazard controller between decode and execute.
// Decides each cycle whether the decode instruction may issue, tracking the ALU/memory
// pipe (EX shadow), the multiplier pipe (per-stage shadow) and the shared write port
// (reservation vector indexed by cycles-from-now).
module issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_src1,
    input  logic [REG_ADDR-1:0] id_src2,
    input  logic                id_use_src2,
    input  logic [REG_ADDR-1:0] id_dest,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_is_mult,
    input  logic                ext_stall,
    output logic                fd_we,
    output logic                id_issue,
    output logic                ex_bubble,
    output logic                wb_sel,
    output logic                mult_busy,
    output logic [1:0]          stall_cause
);

    // Write-back latency measured from the decode cycle.
    localparam int unsigned AluLat  = 3;
    localparam int unsigned MultLat = MULT_LAT + 1;

    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseLoad = 2'b01;
    localparam logic [1:0] CauseMult = 2'b10;
    localparam logic [1:0] CausePort = 2'b11;

    // EX shadow: last ALU-pipe issue
    logic                ex_valid_q, ex_valid_d;
    logic [REG_ADDR-1:0] ex_dest_q, ex_dest_d;
    logic                ex_memread_q, ex_memread_d;

    // Multiplier shadow, stage k at index k
    logic [MULT_LAT:1]                   mv_q, mv_d;
    logic [MULT_LAT:1][REG_ADDR-1:0]     md_q, md_d;

    // resv_q[k] = write port taken k cycles from now
    logic [MULT_LAT+1:1] resv_q, resv_d;

    logic       wb_sel_q, wb_sel_d;
    logic [1:0] cause_q, cause_d;

    logic       src2_live;
    logic       load_use, mult_haz, port_haz, hazard;
    logic [1:0] cause;

    // Hazard detection; r0 never matches and src2 only counts when it is read
    always_comb begin
        src2_live = id_use_src2 && (id_src2 != '0);

        load_use = ex_valid_q && ex_memread_q && (ex_dest_q != '0) &&
                   ((ex_dest_q == id_src1) || (src2_live && (ex_dest_q == id_src2)));

        mult_haz = 1'b0;
        for (int k = 1; k <= MULT_LAT; k++) begin
            if (mv_q[k] && (md_q[k] != '0)) begin
                if ((md_q[k] == id_src1) || (src2_live && (md_q[k] == id_src2)) ||
                    (id_regwrite && (md_q[k] == id_dest))) begin
                    mult_haz = 1'b1;
                end
            end
        end

        // A mult slot can never be pre-booked, so the mult always wins the port
        port_haz = id_regwrite && (id_is_mult ? resv_q[MultLat] : resv_q[AluLat]);

        if (!id_valid)     cause = CauseNone;
        else if (load_use) cause = CauseLoad;
        else if (mult_haz) cause = CauseMult;
        else if (port_haz) cause = CausePort;
        else               cause = CauseNone;

        hazard = (cause != CauseNone);
    end

    // Issue handshake outputs
    always_comb begin
        id_issue    = id_valid && !hazard && !ext_stall;
        fd_we       = !ext_stall && !(id_valid && hazard);
        ex_bubble   = !ext_stall && !id_issue;
        mult_busy   = |mv_q;
        wb_sel      = wb_sel_q;
        stall_cause = cause_q;
    end

    // Next-state: everything advances together or freezes together on ext_stall
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_dest_d    = ex_dest_q;
        ex_memread_d = ex_memread_q;
        mv_d         = mv_q;
        md_d         = md_q;
        resv_d       = resv_q;
        wb_sel_d     = wb_sel_q;
        cause_d      = cause_q;

        if (!ext_stall) begin
            mv_d    = {mv_q[MULT_LAT-1:1], id_issue && id_is_mult};
            md_d[1] = id_dest;
            for (int k = 2; k <= MULT_LAT; k++) begin
                md_d[k] = md_q[k-1];
            end

            ex_valid_d   = id_issue && !id_is_mult;
            ex_dest_d    = id_dest;
            ex_memread_d = id_memread;

            resv_d = {1'b0, resv_q[MULT_LAT+1:2]};
            if (id_issue && id_regwrite) begin
                if (id_is_mult) resv_d[MultLat-1] = 1'b1;
                else            resv_d[AluLat-1]  = 1'b1;
            end

            wb_sel_d = mv_q[MULT_LAT];
            cause_d  = cause;
        end
    end

    // State registers; reset discards all in-flight tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q   <= 1'b0;
            ex_dest_q    <= '0;
            ex_memread_q <= 1'b0;
            mv_q         <= '0;
            md_q         <= '0;
            resv_q       <= '0;
            wb_sel_q     <= 1'b0;
            cause_q      <= CauseNone;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_dest_q    <= ex_dest_d;
            ex_memread_q <= ex_memread_d;
            mv_q         <= mv_d;
            md_q         <= md_d;
            resv_q       <= resv_d;
            wb_sel_q     <= wb_sel_d;
            cause_q      <= cause_d;
        end
    end

endmodule
